// File: rtl/aes_ctr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_pkg
// Brief    : Shared types, defaults and counter helper for the AES CTR front-end
// Revision : 1.0 - initial release
// ============================================================================
package aes_ctr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RUN   = 2'd2,
      ST_OUT   = 2'd3
   } aes_ctr_state_e;

   localparam int unsigned CTR_W_DEFAULT = 32;

   // Increments only the low `width` bits; the carry out of that field is
   // masked so the nonce above it never changes.
   function automatic logic [127:0] ctr_inc(input logic [127:0] blk,
                                            input int unsigned  width);
      logic [127:0] w_mask;
      if (width >= 128)
         w_mask = '1;
      else
         w_mask = (128'd1 << width) - 128'd1;
      return (blk & ~w_mask) | ((blk + 128'd1) & w_mask);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_ctr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_ctrl
// Brief    : CTR-mode front-end: issues counter blocks to the AES core and
//            XORs the returned keystream with buffered plaintext
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctr_ctrl
   import aes_ctr_pkg::*;
#(
   parameter int unsigned CTR_W = CTR_W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,

   input  logic         cfg_v_i,
   output logic         cfg_ready_o,
   input  logic [127:0] cfg_key_i,
   input  logic [127:0] cfg_iv_i,

   input  logic         pt_v_i,
   output logic         pt_ready_o,
   input  logic [127:0] pt_data_i,
   input  logic         pt_last_i,

   output logic         ct_v_o,
   input  logic         ct_ready_i,
   output logic [127:0] ct_data_o,
   output logic         ct_last_o,

   output logic         core_data_v_o,
   output logic [127:0] core_data_o,
   output logic [127:0] core_key_o,
   input  logic         core_res_v_i,
   input  logic [127:0] core_res_i,

   output logic         busy_o
);

   localparam logic [1:0] c_IDLE  = ST_IDLE;
   localparam logic [1:0] c_ISSUE = ST_ISSUE;
   localparam logic [1:0] c_RUN   = ST_RUN;
   localparam logic [1:0] c_OUT   = ST_OUT;

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic         r_key_vld;
   logic [127:0] r_key;
   logic [127:0] r_iv;
   logic [127:0] r_ctr;
   logic [127:0] r_pt;
   logic         r_last;
   logic [127:0] r_ct;

   logic         w_idle;
   logic         w_cfg_hs;
   logic         w_pt_hs;
   logic         w_ct_hs;

   assign w_idle   = (r_state == c_IDLE);
   assign w_cfg_hs = cfg_v_i & cfg_ready_o;
   assign w_pt_hs  = pt_v_i & pt_ready_o;
   assign w_ct_hs  = ct_v_o & ct_ready_i;

   // A pending config always wins over plaintext offered in the same cycle.
   assign cfg_ready_o   = w_idle;
   assign pt_ready_o    = w_idle & r_key_vld & ~cfg_v_i;
   assign core_data_v_o = (r_state == c_ISSUE);
   assign core_data_o   = r_ctr;
   assign core_key_o    = r_key;
   assign ct_v_o        = (r_state == c_OUT);
   assign ct_data_o     = r_ct;
   assign ct_last_o     = (r_state == c_OUT) & r_last;
   assign busy_o        = ~w_idle;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_pt_hs)      w_state_nxt = c_ISSUE;
         c_ISSUE:                   w_state_nxt = c_RUN;
         c_RUN:   if (core_res_v_i) w_state_nxt = c_OUT;
         c_OUT:   if (ct_ready_i)   w_state_nxt = c_IDLE;
         default:                   w_state_nxt = c_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_key_vld <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cfg_hs)
            r_key_vld <= 1'b1;
      end
   end

   // Datapath registers carry no reset; every use is qualified by the FSM.
   always_ff @(posedge clk) begin
      if (w_cfg_hs) begin
         r_key <= cfg_key_i;
         r_iv  <= cfg_iv_i;
         r_ctr <= cfg_iv_i;
      end else if (r_state == c_ISSUE) begin
         r_ctr <= ctr_inc(r_ctr, CTR_W);
      end else if (w_ct_hs && r_last) begin
         r_ctr <= r_iv;
      end

      if (w_pt_hs) begin
         r_pt   <= pt_data_i;
         r_last <= pt_last_i;
      end

      if ((r_state == c_RUN) && core_res_v_i)
         r_ct <= core_res_i ^ r_pt;
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctr_ctrl
// Brief    : Scoreboard bench for aes_ctr_ctrl with a behavioural AES core stub
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctr_ctrl;

   localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV1   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] CTR2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
   localparam logic [127:0] PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CT1   = 128'h874d6191b620e3261bef6864990db6ce;
   localparam logic [127:0] PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] CT2   = 128'h9806f66b7970fdff8617187bb9fffdff;
   localparam logic [127:0] IVW   = 128'h000102030405060708090a0bffffffff;
   localparam logic [127:0] CTRW2 = 128'h000102030405060708090a0b00000000;
   localparam logic [127:0] PTA   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PTB   = 128'hdeadbeefcafef00d0badc0de12345678;
   localparam logic [127:0] PTC   = 128'h0123456789abcdeffedcba9876543210;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_v_i, cfg_ready_o;
   logic [127:0] cfg_key_i, cfg_iv_i;
   logic         pt_v_i, pt_ready_o, pt_last_i;
   logic [127:0] pt_data_i;
   logic         ct_v_o, ct_ready_i, ct_last_o;
   logic [127:0] ct_data_o;
   logic         core_data_v_o, core_res_v_i;
   logic [127:0] core_data_o, core_key_o, core_res_i;
   logic         busy_o;

   aes_ctr_ctrl #(.CTR_W(32)) dut (
      .clk(clk), .reset(reset),
      .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o), .cfg_key_i(cfg_key_i), .cfg_iv_i(cfg_iv_i),
      .pt_v_i(pt_v_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i), .pt_last_i(pt_last_i),
      .ct_v_o(ct_v_o), .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o), .ct_last_o(ct_last_o),
      .core_data_v_o(core_data_v_o), .core_data_o(core_data_o), .core_key_o(core_key_o),
      .core_res_v_i(core_res_v_i), .core_res_i(core_res_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int n_req    = 0;
   int n_ct     = 0;

   typedef struct {
      logic [127:0] data;
      logic         last;
      int           hs;
   } exp_t;

   exp_t req_q[$];
   exp_t ct_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   // Stub keystream: real F.5.1 keystream for the two NIST counters, ~ctr otherwise.
   function automatic logic [127:0] ks(input logic [127:0] c);
      if (c == IV1)       return PT1 ^ CT1;
      else if (c == CTR2) return PT2 ^ CT2;
      else                return ~c;
   endfunction

   // Core stub: answers 11 cycles after each request, forgets it on reset.
   initial begin
      int           m_cnt;
      logic [127:0] m_ctr;
      exp_t         e;
      m_cnt = 0;
      m_ctr = '0;
      core_res_v_i = 1'b0;
      core_res_i   = '0;
      forever begin
         @(negedge clk);
         #1;
         core_res_v_i = 1'b0;
         if (reset) begin
            m_cnt = 0;
         end else begin
            if (m_cnt > 0) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  core_res_v_i = 1'b1;
                  core_res_i   = ks(m_ctr);
               end
            end
            if (core_data_v_o) begin
               n_req++;
               check("core_idle_at_req", m_cnt, 0);
               check("core_key", core_key_o, KEY);
               if (req_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL req_unexpected: got %h expected none", core_data_o);
               end else begin
                  e = req_q.pop_front();
                  check("core_data", core_data_o, e.data);
                  check("req_latency", cyc - e.hs, 1);
               end
               m_ctr = core_data_o;
               m_cnt = 11;
            end
         end
      end
   end

   // Ciphertext monitor.
   initial begin
      logic prev_v;
      exp_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (ct_v_o && !prev_v && ct_q.size() != 0)
            check("ct_latency", cyc - ct_q[0].hs, 13);
         if (ct_v_o && ct_ready_i) begin
            n_ct++;
            if (ct_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL ct_unexpected: got %h expected none", ct_data_o);
            end else begin
               e = ct_q.pop_front();
               check("ct_data", ct_data_o, e.data);
               check("ct_last", ct_last_o, e.last);
            end
         end
         prev_v = ct_v_o;
      end
   end

   task automatic push_exp(input logic [127:0] exp_ctr, input logic [127:0] exp_ct,
                           input logic l, input int hs);
      exp_t e;
      e.data = exp_ctr; e.last = 1'b0; e.hs = hs;
      req_q.push_back(e);
      e.data = exp_ct;  e.last = l;    e.hs = hs;
      ct_q.push_back(e);
   endtask

   task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv);
      int t;
      t = 0;
      @(negedge clk);
      cfg_v_i = 1'b1; cfg_key_i = k; cfg_iv_i = iv;
      while (!cfg_ready_o && t < 200) begin @(negedge clk); t++; end
      if (!cfg_ready_o) fail_now("cfg_timeout");
      @(negedge clk);
      cfg_v_i = 1'b0;
   endtask

   task automatic send_pt(input logic [127:0] d, input logic l, input logic [127:0] exp_ctr,
                          input logic [127:0] exp_ct, output int hs);
      int t;
      t = 0;
      hs = -100;
      @(negedge clk);
      pt_v_i = 1'b1; pt_data_i = d; pt_last_i = l;
      while (!pt_ready_o && t < 200) begin @(negedge clk); t++; end
      if (!pt_ready_o) begin
         fail_now("pt_timeout");
         pt_v_i = 1'b0;
      end else begin
         hs = cyc;
         push_exp(exp_ctr, exp_ct, l, hs);
         @(negedge clk);
         pt_v_i = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin @(negedge clk); t++; end
      while ((ct_q.size() != 0 || busy_o) && t < 500);
      if (t >= 500) fail_now("idle_timeout");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cfg_ready"}, cfg_ready_o, 1);
      check({tag, "_pt_ready"}, pt_ready_o, 0);
      check({tag, "_ct_v"}, ct_v_o, 0);
      check({tag, "_ct_last"}, ct_last_o, 0);
      check({tag, "_core_v"}, core_data_v_o, 0);
      check({tag, "_busy"}, busy_o, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int hs, t, req0, ct0;
      logic [127:0] hold;
      logic stable;
      reset = 1'b1;
      cfg_v_i = 1'b0; cfg_key_i = '0; cfg_iv_i = '0;
      pt_v_i = 1'b0; pt_data_i = '0; pt_last_i = 1'b0;
      ct_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // NIST F.5.1 block 1 with timing at T+1 / T+13 / T+14
      do_cfg(KEY, IV1);
      #1;
      check("pt_ready_after_cfg", pt_ready_o, 1);
      check("key_after_cfg", core_key_o, KEY);
      send_pt(PT1, 1'b0, IV1, CT1, hs);
      check("busy_issue", busy_o, 1);
      check("pt_ready_busy", pt_ready_o, 0);
      t = 0;
      while (cyc < hs + 14 && t < 100) begin @(negedge clk); t++; end
      check("pt_ready_T14", pt_ready_o, 1);
      check("busy_T14", busy_o, 0);

      // Block 2 marked last, then counter restarts at iv
      send_pt(PT2, 1'b1, CTR2, CT2, hs);
      wait_idle();
      send_pt(PT1, 1'b0, IV1, CT1, hs);
      wait_idle();

      // cfg and pt together: cfg wins, pt accepted the following cycle
      @(negedge clk);
      cfg_v_i = 1'b1; cfg_key_i = KEY; cfg_iv_i = IVW;
      pt_v_i = 1'b1; pt_data_i = PTA; pt_last_i = 1'b0;
      #1;
      check("prio_pt_ready", pt_ready_o, 0);
      check("prio_cfg_ready", cfg_ready_o, 1);
      @(negedge clk);
      cfg_v_i = 1'b0;
      #1;
      check("prio_pt_next", pt_ready_o, 1);
      push_exp(IVW, PTA ^ ~IVW, 1'b0, cyc);
      @(negedge clk);
      pt_v_i = 1'b0;
      wait_idle();

      // Low-field wrap
      send_pt(PTB, 1'b1, CTRW2, PTB ^ ~CTRW2, hs);
      wait_idle();

      // Backpressure for 20 cycles
      ct_ready_i = 1'b0;
      req0 = n_req;
      ct0  = n_ct;
      send_pt(PTC, 1'b1, IVW, PTC ^ ~IVW, hs);
      t = 0;
      while (!ct_v_o && t < 100) begin @(negedge clk); t++; end
      if (!ct_v_o) fail_now("bp_ct_v_timeout");
      hold   = ct_data_o;
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!ct_v_o || ct_data_o !== hold || pt_ready_o || ct_last_o !== 1'b1) stable = 1'b0;
      end
      check("bp_stable", stable, 1);
      check("bp_req_pulses", n_req - req0, 1);
      check("bp_no_hs", n_ct - ct0, 0);
      ct_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check("bp_one_hs", n_ct - ct0, 1);
      wait_idle();

      // Reset in RUN discards the block and the key
      send_pt(PTA, 1'b0, IVW, PTA ^ ~IVW, hs);
      t = 0;
      while (cyc < hs + 5 && t < 100) begin @(negedge clk); t++; end
      check("run_busy", busy_o, 1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      ct_q.delete();
      reset = 1'b0;
      ct0 = n_ct;
      repeat (20) @(negedge clk);
      check("midrst_no_ct", n_ct - ct0, 0);
      check("midrst_pt_ready", pt_ready_o, 0);

      // Recovery after reconfiguration
      do_cfg(KEY, IV1);
      send_pt(PT1, 1'b0, IV1, CT1, hs);
      wait_idle();

      check("req_q_empty", req_q.size(), 0);
      check("ct_q_empty", ct_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
